// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Walks the asynchronous read port of a register file from address 0 to NUM_REGS-1
// after Start. Each {address, data} pair is streamed out through a registered
// valid/ready output stage.
//
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   Start              dump request, sampled only while idle
//   Busy, Done         dump in progress / one-cycle completion pulse
//   rd_add, rd_data    register file read address and its combinational read data
//   Out_valid/ready    output handshake
//   Out_add, Out_data  register index and contents of the current beat
//   Out_last           final beat of the dump
//   Out_is_chk         beat carries the checksum word
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra beat after the
// last register. That beat carries the XOR of every register word, with Out_is_chk=1
// and Out_add=0. When the macro is undefined, Out_is_chk is tied to 0.

module regfile_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] rd_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [ADDR_W-1:0] Out_add,
    output logic [DATA_W-1:0] Out_data,
    output logic              Out_last,
    output logic              Out_is_chk
);

    // One extra index bit lets NUM_REGS == 2**ADDR_W terminate without wrap-around.
    localparam int unsigned IdxW    = ADDR_W + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              load;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              is_chk_q, is_chk_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        add_d   = add_q;
        data_d  = data_q;
        last_d  = last_q;
        rd_add  = '0;
        load    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk_d    = chk_q;
        is_chk_d = is_chk_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRead;
                    idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end

            StRead: begin
                // The output register advances when it is empty or being drained this cycle.
                load = !valid_q || Out_ready;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                if (idx_q == IdxW'(NUM_REGS)) begin
                    // All registers have been captured; emit the checksum beat.
                    if (load) begin
                        valid_d  = 1'b1;
                        data_d   = chk_q;
                        add_d    = '0;
                        last_d   = 1'b1;
                        is_chk_d = 1'b1;
                        state_d  = StDrain;
                    end
                end else begin
                    rd_add = idx_q[ADDR_W-1:0];
                    if (load) begin
                        valid_d  = 1'b1;
                        data_d   = rd_data;
                        add_d    = idx_q[ADDR_W-1:0];
                        last_d   = 1'b0;
                        is_chk_d = 1'b0;
                        chk_d    = chk_q ^ rd_data;
                        idx_d    = idx_q + IdxW'(1);
                    end
                end
`else
                rd_add = idx_q[ADDR_W-1:0];
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = rd_data;
                    add_d   = idx_q[ADDR_W-1:0];
                    last_d  = (idx_q == LastIdx);
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
`endif
            end

            StDrain: begin
                if (Out_ready) begin
                    valid_d = 1'b0;
                    state_d = StDone;
                end
            end

            StDone: begin
                // Start is deliberately not sampled here.
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            valid_q <= 1'b0;
            add_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            add_q   <= add_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            chk_q    <= '0;
            is_chk_q <= 1'b0;
        end else begin
            chk_q    <= chk_d;
            is_chk_q <= is_chk_d;
        end
    end

    assign Out_is_chk = is_chk_q;
`else
    assign Out_is_chk = 1'b0;
`endif

    assign Busy      = (state_q == StRead) || (state_q == StDrain);
    assign Done      = (state_q == StDone);
    assign Out_valid = valid_q;
    assign Out_add   = add_q;
    assign Out_data  = data_q;
    assign Out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    localparam int NRegs = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif
    localparam int NBeats = NRegs + (ChkEn ? 1 : 0);
    localparam int Extra  = ChkEn ? 1 : 0;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start = 1'b0;
    logic        Busy, Done;
    logic [4:0]  rd_add;
    logic [31:0] rd_data;
    logic        Out_valid;
    logic        Out_ready = 1'b1;
    logic [4:0]  Out_add;
    logic [31:0] Out_data;
    logic        Out_last, Out_is_chk;

    logic [31:0] regs [NRegs];
    assign rd_data = regs[rd_add];

    regfile_dump_reader #(
        .NUM_REGS(NRegs),
        .ADDR_W  (5),
        .DATA_W  (32)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .rd_add    (rd_add),
        .rd_data   (rd_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_add   (Out_add),
        .Out_data  (Out_data),
        .Out_last  (Out_last),
        .Out_is_chk(Out_is_chk)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  add;
        logic [31:0] data;
        logic        last;
        logic        is_chk;
    } beat_t;

    typedef struct {
        int stall_beat;
        int stall_len;
        int restart_a;
        int restart_b;
        bit start_at_done;
        int exp_done;
    } dump_vec_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream for one dump; ovr_idx replaces one register's expected value.
    function automatic void push_dump(input int ovr_idx, input logic [31:0] ovr_val);
        logic [31:0] x;
        logic [31:0] d;
        beat_t       b;
        x = '0;
        for (int i = 0; i < NRegs; i++) begin
            d = (i == ovr_idx) ? ovr_val : regs[i];
            x = x ^ d;
            b.add    = 5'(i);
            b.data   = d;
            b.last   = (i == NRegs - 1) && !ChkEn;
            b.is_chk = 1'b0;
            exp_q.push_back(b);
        end
        if (ChkEn) begin
            b.add    = '0;
            b.data   = x;
            b.last   = 1'b1;
            b.is_chk = 1'b1;
            exp_q.push_back(b);
        end
    endfunction

    // Output monitor: pops the scoreboard on each accepted beat, checks hold while stalled.
    logic        hold_v = 1'b0;
    logic [4:0]  hold_add;
    logic [31:0] hold_data;
    beat_t       mon_e;

    always @(negedge CLK) begin
        if (RESET) begin
            hold_v = 1'b0;
        end else begin
            if (Done) done_cnt++;
            if (Out_valid) begin
                if (hold_v) begin
                    check("hold_add", 64'(Out_add), 64'(hold_add));
                    check("hold_data", 64'(Out_data), 64'(hold_data));
                end
                if (Out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL extra_beat: add %0d data %0h with empty scoreboard",
                                 Out_add, Out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_add", 64'(Out_add), 64'(mon_e.add));
                        check("beat_data", 64'(Out_data), 64'(mon_e.data));
                        check("beat_last", 64'(Out_last), 64'(mon_e.last));
                        check("beat_is_chk", 64'(Out_is_chk), 64'(mon_e.is_chk));
                    end
                    beat_cnt++;
                    hold_v = 1'b0;
                end else begin
                    hold_v    = 1'b1;
                    hold_add  = Out_add;
                    hold_data = Out_data;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic do_dump(input dump_vec_t v);
        int cyc, done_cyc, first_v, stall_left, b0, d0;
        bit stall_done;
        b0 = beat_cnt;
        d0 = done_cnt;
        done_cyc = -1;
        first_v = -1;
        stall_left = v.stall_len;
        stall_done = 1'b0;
        push_dump(-1, '0);
        @(posedge CLK); #1;
        Start = 1'b1;
        Out_ready = 1'b1;
        cyc = 0;
        while (cyc < 200 && done_cyc < 0) begin
            @(posedge CLK); #1;
            cyc++;
            Start = 1'b0;
            if (Out_valid && first_v < 0) first_v = cyc;
            if (Done) begin
                done_cyc = cyc;
                if (v.start_at_done) Start = 1'b1;
            end
            if (Out_valid && (32'(Out_add) == v.restart_a || 32'(Out_add) == v.restart_b))
                Start = 1'b1;
            if (!stall_done && Out_valid && 32'(Out_add) == v.stall_beat) begin
                if (stall_left > 0) begin
                    Out_ready = 1'b0;
                    stall_left--;
                end else begin
                    Out_ready = 1'b1;
                    stall_done = 1'b1;
                end
            end
        end
        check("first_valid_cycle", 64'(first_v), 64'(2));
        check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("done_pulses", 64'(done_cnt - d0), 64'(1));
        check("beat_total", 64'(beat_cnt - b0), 64'(NBeats));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("busy_after", 64'(Busy), 64'(0));
        check("valid_after", 64'(Out_valid), 64'(0));
    endtask

    task automatic reset_mid_dump();
        int cyc, b0, d0;
        bit hit;
        b0 = beat_cnt;
        push_dump(-1, '0);
        @(posedge CLK); #1;
        Start = 1'b1;
        Out_ready = 1'b1;
        hit = 1'b0;
        cyc = 0;
        while (cyc < 100 && !hit) begin
            @(posedge CLK); #1;
            cyc++;
            Start = 1'b0;
            if (Out_valid && Out_add == 5'd12) hit = 1'b1;
        end
        check("reached_beat12", 64'(hit), 64'(1));
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        d0 = done_cnt;
        check("rst_valid", 64'(Out_valid), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_rd_add", 64'(rd_add), 64'(0));
        check("rst_done", 64'(Done), 64'(0));
        check("rst_beats_before", 64'(beat_cnt - b0), 64'(12));
        exp_q.delete();
        repeat (5) @(posedge CLK);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 64'(0));
        check("rst_idle_busy", 64'(Busy), 64'(0));
    endtask

    task automatic coherence();
        int cyc;
        bit written, late, fin;
        push_dump(3, 32'hDEADBEEF);
        @(posedge CLK); #1;
        Start = 1'b1;
        Out_ready = 1'b1;
        written = 1'b0;
        late = 1'b0;
        fin = 1'b0;
        cyc = 0;
        while (cyc < 200 && !fin) begin
            @(posedge CLK); #1;
            cyc++;
            Start = 1'b0;
            if (Done) fin = 1'b1;
            if (!written && Busy && rd_add == 5'd3) begin
                @(negedge CLK);
                regs[3] = 32'hDEADBEEF;
                written = 1'b1;
            end else if (written && !late && Out_valid && Out_add == 5'd4) begin
                regs[3] = 32'h12345678;
                late = 1'b1;
            end
        end
        check("coh_done", 64'(fin), 64'(1));
        check("coh_late_write", 64'(late), 64'(1));
        check("coh_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        regs[3] = 32'h33333333;
    endtask

    dump_vec_t vecs [3];

    initial begin
        vecs[0] = '{stall_beat: -1, stall_len: 0, restart_a: -1, restart_b: -1,
                    start_at_done: 1'b0, exp_done: 34 + Extra};
        vecs[1] = '{stall_beat: 5, stall_len: 3, restart_a: -1, restart_b: -1,
                    start_at_done: 1'b0, exp_done: 37 + Extra};
        vecs[2] = '{stall_beat: -1, stall_len: 0, restart_a: 10, restart_b: 20,
                    start_at_done: 1'b1, exp_done: 34 + Extra};

        for (int i = 0; i < NRegs; i++) regs[i] = 32'(i) * 32'h11111111;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 64'(Busy), 64'(0));
        check("reset_done", 64'(Done), 64'(0));
        check("reset_valid", 64'(Out_valid), 64'(0));
        check("reset_add", 64'(Out_add), 64'(0));
        check("reset_data", 64'(Out_data), 64'(0));
        check("reset_last", 64'(Out_last), 64'(0));
        check("reset_is_chk", 64'(Out_is_chk), 64'(0));
        check("reset_rd_add", 64'(rd_add), 64'(0));
        RESET = 1'b0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 3; i++) do_dump(vecs[i]);

        reset_mid_dump();
        do_dump(vecs[0]);
        coherence();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule
